data_sync_mc: RTL and testbench

- Multi-channel destination-domain bus synchronizer; next generation of the single-channel enable-qualified data synchronizer.
- Each of NUM_CH channels carries a source-stable bus plus an enable. The enable is synchronized through NUM_STAGES flops and edge-detected, and the bus is captured into a per-channel hold register.
- A round-robin arbiter drains pending channels into one output slot with a valid/ready handshake.
- Sits at clock-domain entry points where several slow sources share one consumer (e.g. register-file / UART RX paths).

---
 rtl/data_sync_mc.sv | 181 ++++++++++++++++++
 tb/tb_data_sync_mc.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_mc.sv
// data_sync_mc: multi-channel destination-domain bus synchronizer.
// Each channel's asynchronous enable passes through a NUM_STAGES flop chain
// and is edge-detected. A detected event captures that channel's slice of
// unsync_bus into a hold register and marks it pending. A round-robin arbiter
// moves pending words into one output slot that uses a valid/ready handshake.
//
// Optional feature: define DATA_SYNC_MC_OVR_EN to add sticky per-channel
// overrun flags (output overrun) and their clears (input clr_overrun).
//
// Ports:
//   CLK         destination clock
//   RST         asynchronous active-high reset
//   unsync_bus  channel c data at [c*BUS_WIDTH +: BUS_WIDTH]
//   bus_enable  per-channel async enable (level, or toggle when EN_MODE=1)
//   out_ready   consumer accepts the output slot
//   clr_overrun (OVR_EN only) per-channel overrun clear
//   overrun     (OVR_EN only) sticky per-channel overrun flags
//   sync_bus    output data
//   sync_ch     channel index of sync_bus
//   sync_valid  output slot holds valid data
//   ack         per-channel toggle, flips when that channel enters the slot
module data_sync_mc #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned EN_MODE    = 0,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic                        out_ready,
`ifdef DATA_SYNC_MC_OVR_EN
  input  logic [NUM_CH-1:0]           clr_overrun,
  output logic [NUM_CH-1:0]           overrun,
`endif
  output logic [BUS_WIDTH-1:0]        sync_bus,
  output logic [CH_W-1:0]             sync_ch,
  output logic                        sync_valid,
  output logic [NUM_CH-1:0]           ack
);

  logic [NUM_STAGES-1:0] sync_q [NUM_CH];
  logic [NUM_CH-1:0]     prev_q;
  logic [NUM_CH-1:0]     ev;

  logic [BUS_WIDTH-1:0]  hold_q [NUM_CH];
  logic [BUS_WIDTH-1:0]  hold_d [NUM_CH];
  logic [NUM_CH-1:0]     pend_q, pend_d;
  logic [NUM_CH-1:0]     ack_q, ack_d;
  logic [CH_W-1:0]       ptr_q, ptr_d;
  logic [BUS_WIDTH-1:0]  bus_q, bus_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  valid_q, valid_d;

  logic                  slot_free;
  logic                  gnt_vld;
  logic                  do_grant;
  logic [CH_W-1:0]       gnt_idx;
  logic [CH_W-1:0]       cand;
  logic [NUM_CH-1:0]     gnt_hit;

  // Synchronizer chain plus the previous-value register for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned c = 0; c < NUM_CH; c++) sync_q[c] <= '0;
      prev_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        sync_q[c] <= {sync_q[c][NUM_STAGES-2:0], bus_enable[c]};
        prev_q[c] <= sync_q[c][NUM_STAGES-1];
      end
    end
  end

  always_comb begin
    ev = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (EN_MODE != 0) ev[c] = sync_q[c][NUM_STAGES-1] ^ prev_q[c];
      else              ev[c] = sync_q[c][NUM_STAGES-1] & ~prev_q[c];
    end
  end

  // Round-robin search: first pending channel at or above ptr_q, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((32'(ptr_q) + i) % NUM_CH);
      if (!gnt_vld && pend_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign slot_free = ~valid_q | out_ready;
  assign do_grant  = slot_free & gnt_vld;

  always_comb begin
    gnt_hit = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      gnt_hit[c] = do_grant && (gnt_idx == CH_W'(c));
  end

  always_comb begin
    pend_d  = pend_q;
    hold_d  = hold_q;
    ack_d   = ack_q;
    ptr_d   = ptr_q;
    bus_d   = bus_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    if (slot_free) begin
      if (do_grant) begin
        bus_d            = hold_q[gnt_idx];
        ch_d             = gnt_idx;
        valid_d          = 1'b1;
        ptr_d            = CH_W'((32'(gnt_idx) + 1) % NUM_CH);
        pend_d[gnt_idx]  = 1'b0;
        ack_d[gnt_idx]   = ~ack_q[gnt_idx];
      end else begin
        valid_d = 1'b0;
      end
    end
    // A channel granted this cycle has already handed its old hold value to
    // the slot, so a coincident event refills the hold and re-arms pend.
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ev[c] && (!pend_q[c] || gnt_hit[c])) begin
        hold_d[c] = unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
        pend_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned c = 0; c < NUM_CH; c++) hold_q[c] <= '0;
      pend_q  <= '0;
      ack_q   <= '0;
      ptr_q   <= '0;
      bus_q   <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) hold_q[c] <= hold_d[c];
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
      bus_q   <= bus_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

`ifdef DATA_SYNC_MC_OVR_EN
  logic [NUM_CH-1:0] ovr_q, ovr_d;

  // Clear first, then set, so a new overrun wins over a same-cycle clear.
  always_comb begin
    ovr_d = ovr_q & ~clr_overrun;
    for (int unsigned c = 0; c < NUM_CH; c++)
      if (ev[c] && pend_q[c] && !gnt_hit[c]) ovr_d[c] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ovr_q <= '0;
    else     ovr_q <= ovr_d;
  end

  assign overrun = ovr_q;
`endif

  assign sync_bus   = bus_q;
  assign sync_ch    = ch_q;
  assign sync_valid = valid_q;
  assign ack        = ack_q;

endmodule

// File: tb/tb_data_sync_mc.sv
// tb_data_sync_mc: directed self-checking bench for data_sync_mc.
// Two instances: dut (level enables, EN_MODE=0) and dut_t (toggle enables,
// EN_MODE=1). Expected words are queued when stimulus is driven and are
// popped by per-instance monitors whenever a word is accepted.
module tb_data_sync_mc;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] unsync_bus;
  logic [3:0]  bus_enable;
  logic        out_ready;
  logic [7:0]  sync_bus;
  logic [1:0]  sync_ch;
  logic        sync_valid;
  logic [3:0]  ack;

  logic [31:0] bus_t;
  logic [3:0]  en_t;
  logic        ready_t;
  logic [7:0]  sync_bus_t;
  logic [1:0]  sync_ch_t;
  logic        sync_valid_t;
  logic [3:0]  ack_t;

`ifdef DATA_SYNC_MC_OVR_EN
  logic [3:0]  clr_overrun;
  logic [3:0]  overrun;
  logic [3:0]  overrun_t;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q   [$];
  logic [31:0] q_t [$];

  always #5 CLK = ~CLK;

  data_sync_mc #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(4), .EN_MODE(0)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .unsync_bus (unsync_bus),
    .bus_enable (bus_enable),
    .out_ready  (out_ready),
`ifdef DATA_SYNC_MC_OVR_EN
    .clr_overrun(clr_overrun),
    .overrun    (overrun),
`endif
    .sync_bus   (sync_bus),
    .sync_ch    (sync_ch),
    .sync_valid (sync_valid),
    .ack        (ack)
  );

  data_sync_mc #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(4), .EN_MODE(1)) dut_t (
    .CLK        (CLK),
    .RST        (RST),
    .unsync_bus (bus_t),
    .bus_enable (en_t),
    .out_ready  (ready_t),
`ifdef DATA_SYNC_MC_OVR_EN
    .clr_overrun(4'b0000),
    .overrun    (overrun_t),
`endif
    .sync_bus   (sync_bus_t),
    .sync_ch    (sync_ch_t),
    .sync_valid (sync_valid_t),
    .ack        (ack_t)
  );

  function automatic logic [31:0] w(input logic [1:0] ch, input logic [7:0] d);
    return {22'd0, ch, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // A word is accepted at the next rising edge when valid & ready at negedge.
  always @(negedge CLK) begin
    if (!RST && sync_valid && out_ready) begin
      n_vec++;
      assert (q.size() > 0) else begin
        n_err++;
        $error("FAIL mon_unexpected: observed ch%0d %0h expected none", sync_ch, sync_bus);
      end
      if (q.size() > 0) chk("mon_word", w(sync_ch, sync_bus), q.pop_front());
    end
  end

  always @(negedge CLK) begin
    if (!RST && sync_valid_t && ready_t) begin
      n_vec++;
      assert (q_t.size() > 0) else begin
        n_err++;
        $error("FAIL mon_t_unexpected: observed ch%0d %0h expected none", sync_ch_t, sync_bus_t);
      end
      if (q_t.size() > 0) chk("mon_t_word", w(sync_ch_t, sync_bus_t), q_t.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    RST        = 1'b1;
    unsync_bus = '0;
    bus_enable = '0;
    out_ready  = 1'b0;
    bus_t      = '0;
    en_t       = '0;
    ready_t    = 1'b1;
`ifdef DATA_SYNC_MC_OVR_EN
    clr_overrun = '0;
`endif
    tick(2);
    chk("rst_valid", 32'(sync_valid), 32'd0);
    chk("rst_bus",   32'(sync_bus),   32'd0);
    chk("rst_ch",    32'(sync_ch),    32'd0);
    chk("rst_ack",   32'(ack),        32'd0);
    RST = 1'b0;
    tick(1);

    // Asynchronous reset while a word sits in the slot with ready low.
    unsync_bus[0 +: 8] = 8'h99;
    bus_enable[0]      = 1'b1;
    tick(4);
    chk("pre_rst_valid", 32'(sync_valid), 32'd1);
    chk("pre_rst_ack",   32'(ack),        32'b0001);
    #2;
    RST        = 1'b1;
    bus_enable = '0;
    #1;
    chk("async_valid", 32'(sync_valid), 32'd0);
    chk("async_bus",   32'(sync_bus),   32'd0);
    chk("async_ch",    32'(sync_ch),    32'd0);
    chk("async_ack",   32'(ack),        32'd0);
    tick(2);
    RST = 1'b0;
    tick(1);

    // Single channel latency: valid appears at the fourth edge.
    unsync_bus[16 +: 8] = 8'hA5;
    bus_enable[2]       = 1'b1;
    tick(3);
    chk("lat_not_yet", 32'(sync_valid), 32'd0);
    tick(1);
    chk("lat_valid", 32'(sync_valid), 32'd1);
    chk("lat_bus",   32'(sync_bus),   32'hA5);
    chk("lat_ch",    32'(sync_ch),    32'd2);
    chk("lat_ack",   32'(ack),        32'b0100);
    q.push_back(w(2'd2, 8'hA5));
    out_ready = 1'b1;
    tick(2);
    chk("lat_drain", 32'(q.size()), 32'd0);

    // Reset again so the round-robin pointer starts at 0.
    bus_enable = '0;
    tick(2);
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(1);
    chk("rst2_ack", 32'(ack), 32'd0);

    // All four channels fire together: consecutive ch0..ch3.
    unsync_bus = {8'h13, 8'h12, 8'h11, 8'h10};
    bus_enable = 4'hF;
    for (int i = 0; i < 4; i++) q.push_back(w(2'(i), 8'(8'h10 + i)));
    tick(4);
    chk("rr_ch0", 32'(sync_ch), 32'd0);
    tick(1);
    chk("rr_ch1", 32'(sync_ch), 32'd1);
    tick(1);
    chk("rr_ch2", 32'(sync_ch), 32'd2);
    tick(1);
    chk("rr_ch3", 32'(sync_ch), 32'd3);
    tick(2);
    chk("rr_drain", 32'(q.size()), 32'd0);
    chk("rr_ack",   32'(ack),      32'b1111);

    // Pointer wrapped to 0: ch0 wins over ch3.
    bus_enable = '0;
    tick(4);
    unsync_bus[0 +: 8]  = 8'h20;
    unsync_bus[24 +: 8] = 8'h23;
    bus_enable          = 4'b1001;
    q.push_back(w(2'd0, 8'h20));
    q.push_back(w(2'd3, 8'h23));
    tick(8);
    chk("wrap_drain", 32'(q.size()), 32'd0);
    chk("wrap_ack",   32'(ack),      32'b0110);

    // Backpressure: slot stable for five cycles, ch1 refires meanwhile.
    bus_enable = '0;
    out_ready  = 1'b0;
    tick(4);
    unsync_bus[8 +: 8] = 8'h3C;
    bus_enable[1]      = 1'b1;
    tick(4);
    q.push_back(w(2'd1, 8'h3C));
    bus_enable[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        unsync_bus[8 +: 8] = 8'h77;
        bus_enable[1]      = 1'b1;
      end
      tick(1);
      chk("bp_valid", 32'(sync_valid), 32'd1);
      chk("bp_bus",   32'(sync_bus),   32'h3C);
      chk("bp_ch",    32'(sync_ch),    32'd1);
    end
    q.push_back(w(2'd1, 8'h77));
    out_ready = 1'b1;
    tick(4);
    chk("bp_drain", 32'(q.size()), 32'd0);
    chk("bp_ack",   32'(ack),      32'b0110);

    // Same-cycle grant and new event on ch1 (pointer is 2 here).
    bus_enable = '0;
    out_ready  = 1'b0;
    tick(4);
    unsync_bus[0 +: 8] = 8'h40;
    unsync_bus[8 +: 8] = 8'h51;
    bus_enable         = 4'b0011;
    tick(4);
    chk("sc_slot_ch",  32'(sync_ch),  32'd0);
    chk("sc_slot_bus", 32'(sync_bus), 32'h40);
    q.push_back(w(2'd0, 8'h40));
    bus_enable[1] = 1'b0;
    tick(2);
    unsync_bus[8 +: 8] = 8'h52;
    bus_enable[1]      = 1'b1;
    tick(2);
    // The event is live now; freeing the slot grants ch1 on the same edge.
    out_ready = 1'b1;
    q.push_back(w(2'd1, 8'h51));
    q.push_back(w(2'd1, 8'h52));
    tick(1);
    chk("sc_grant_bus", 32'(sync_bus), 32'h51);
`ifdef DATA_SYNC_MC_OVR_EN
    chk("sc_no_ovr", 32'(overrun), 32'd0);
`endif
    tick(4);
    chk("sc_drain", 32'(q.size()), 32'd0);
    chk("sc_ack",   32'(ack),      32'b0111);

    // Drop-new: second ch0 event while pending and slot blocked.
    bus_enable = '0;
    out_ready  = 1'b0;
    tick(4);
    unsync_bus[0 +: 8]  = 8'h01;
    unsync_bus[16 +: 8] = 8'h60;
    bus_enable          = 4'b0101;
    tick(4);
    chk("ovr_slot_ch", 32'(sync_ch), 32'd2);
    bus_enable[0] = 1'b0;
    tick(2);
    unsync_bus[0 +: 8] = 8'h02;
    bus_enable[0]      = 1'b1;
    tick(4);
`ifdef DATA_SYNC_MC_OVR_EN
    chk("ovr_set", 32'(overrun), 32'b0001);
`endif
    q.push_back(w(2'd2, 8'h60));
    q.push_back(w(2'd0, 8'h01));
    out_ready = 1'b1;
    tick(6);
    chk("ovr_drain", 32'(q.size()), 32'd0);
    chk("ovr_ack",   32'(ack),      32'b0010);
`ifdef DATA_SYNC_MC_OVR_EN
    chk("ovr_sticky", 32'(overrun), 32'b0001);
    clr_overrun = 4'b0001;
    tick(1);
    clr_overrun = '0;
    chk("ovr_clear", 32'(overrun), 32'd0);
`endif

    // Toggle-mode instance: both edges of en_t[3] deliver a word.
    bus_t[24 +: 8] = 8'h5A;
    en_t[3]        = 1'b1;
    q_t.push_back(w(2'd3, 8'h5A));
    tick(10);
    chk("tog_ack1", 32'(ack_t), 32'b1000);
    bus_t[24 +: 8] = 8'hC3;
    en_t[3]        = 1'b0;
    q_t.push_back(w(2'd3, 8'hC3));
    tick(10);
    chk("tog_ack2",  32'(ack_t),       32'b0000);
    chk("tog_drain", 32'(q_t.size()),  32'd0);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
